simd_vector_lsu: RTL
====================

SIMD_VECTOR_LSU -- requirements
Module: simd_vector_lsu

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  LANES  8  vector lanes per request
  LANE_W  32  bits per lane; one memory beat
  ADDR_W  32  memory address width
  REG_AW  3  destination register index width
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising-edge
  reset  in  1  asynchronous, active-low reset
  req_valid  in  1  vector memory request present
  req_ready  out  1  block accepts a request this cycle
  req_write  in  1  1 = vector store, 0 = vector load
  req_addr  in  ADDR_W  base address of lane 0
  req_stride  in  ADDR_W  address increment between lanes
  req_mask  in  LANES  per-lane enable
  req_wdata  in  LANES*LANE_W  store data; lane i = bits [i*LANE_W +: LANE_W]
  req_wa3  in  REG_AW  destination register of a load
  flush  in  1  synchronous abort of the current request
  mem_en  out  1  memory beat valid
  mem_we  out  1  memory write strobe
  mem_addr  out  ADDR_W  beat address
  mem_wdata  out  LANE_W  beat write data
  mem_rdata  in  LANE_W  read data, valid one cycle after a read beat
  resp_valid  out  1  one-cycle completion pulse
  resp_write  out  1  completed request was a store
  resp_rdata  out  LANES*LANE_W  assembled load result
  resp_wa3  out  REG_AW  destination register of the completed load
  busy  out  1  request in flight; drives pipeline stall

Function
REQ-003 FSM states IDLE, ISSUE, DRAIN, DONE; req_ready = (state == IDLE); busy = !req_ready.
REQ-004 A handshake in cycle T (req_valid && req_ready) latches all req_* fields; req_* are ignored while busy.
REQ-005 Accept in T with k active lanes (k>0) -> ISSUE at T+1; one beat per cycle in T+1..T+k, in ascending lane order, skipping masked lanes with no bubble.
REQ-006 Beat for lane i: mem_en=1, mem_addr = req_addr + i*req_stride, modulo 2^ADDR_W (wrap-around is legal); mem_we=req_write; mem_wdata = lane i of req_wdata.
REQ-007 Loads: mem_rdata from the beat issued in cycle C is captured into lane i of resp_rdata at the end of C+1; after the last beat, state DRAIN for one cycle, then DONE at T+k+2.
REQ-008 Stores: after the last beat, go directly to DONE at T+k+1; no DRAIN.
REQ-009 mask all zero: no beats; DONE at T+1.
REQ-010 DONE lasts one cycle with resp_valid=1, resp_write, and resp_wa3 = latched req_wa3; then IDLE. A new request is accepted no earlier than the cycle after DONE.
REQ-011 Masked-off lanes of resp_rdata read as zero; resp_rdata holds its value until the next accepted load.
REQ-012 stride 0 is legal: all beats target one address. For a store, the highest active lane is written last.
REQ-013 flush=1 in any state: next state IDLE, mem_en and mem_we forced 0 in that cycle, no resp_valid; if flush and a handshake occur together, the handshake wins and flush is ignored.
REQ-014 mem_en=0 and mem_we=0 in every state other than ISSUE.

Reset
REQ-015 reset low asynchronously forces: state IDLE, req_ready=1, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_write=0, resp_rdata=0, resp_wa3=0; all latched request fields cleared.
REQ-016 Reset mid-ISSUE or mid-DRAIN abandons the request, with no resp_valid; pending read data is discarded.

Structure
REQ-017 Shared package simd_pkg holds: the FSM state enum; LANES and LANE_W defaults; lane-slice width constant.
REQ-018 One sub-module, simd_lane_scan (combinational): given a remaining-lane mask, returns the next active lane index and a last-lane flag.
REQ-019 Registered outputs only; no combinational path from mem_rdata to resp_*.

Verification
REQ-020 Load, addr=0x100, stride=4, mask=0xFF, mem returns addr value -> beats at 0x100..0x11C on T+1..T+8; resp_valid at T+10; lane i = 0x100+4i.
REQ-021 Store, mask=0b10100101, stride=8, base 0x40 -> exactly 4 beats with mem_we=1, at 0x40, 0x50, 0x68, 0x78 on consecutive cycles; resp_valid at T+5 with resp_write=1.
REQ-022 mask=0 load -> no mem_en; resp_valid at T+1; resp_rdata=0.
REQ-023 base=0xFFFFFFF8, stride=4, mask=0x0F -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-024 flush at the 3rd beat of a load -> mem_en=0 that cycle, IDLE next cycle, no resp_valid; a following request completes correctly.
REQ-025 reset asserted during DRAIN -> all outputs at reset values immediately; req_ready=1 after release.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD vector load/store unit.
package simd_pkg;

  localparam int unsigned LANES_DEF = 8;
  localparam int unsigned SLICE_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } lsuState_e;

  // Index width for n lanes; never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simd_lane_scan.sv
// Finds the lowest set lane of a mask and whether it is the only one left.
module simd_lane_scan
  import simd_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned IDX_W = idxWidth(LANES)
) (
  input  logic [LANES-1:0] laneMask,
  output logic [IDX_W-1:0] nextLane,
  output logic             anyLane,
  output logic             lastLane
);

  // Descending walk so the lowest active lane wins.
  always_comb begin
    nextLane = '0;
    anyLane  = 1'b0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (laneMask[IDX_W'(i)]) begin
        nextLane = IDX_W'(i);
        anyLane  = 1'b1;
      end
    end
  end

  assign lastLane = anyLane && ((laneMask & ~(LANES'(1) << nextLane)) == '0);

endmodule

// File: rtl/simd_vector_lsu.sv
// Vector load/store unit: serialises one masked, strided vector request into
// single-lane memory beats and assembles load data into a response vector.
module simd_vector_lsu
  import simd_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = SLICE_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [LANES-1:0]        req_mask,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  input  logic [REG_AW-1:0]       req_wa3,
  input  logic                    flush,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    resp_valid,
  output logic                    resp_write,
  output logic [LANES*LANE_W-1:0] resp_rdata,
  output logic [REG_AW-1:0]       resp_wa3,
  output logic                    busy
);

  localparam int unsigned IDX_W = idxWidth(LANES);
  localparam int unsigned DW    = LANES * LANE_W;
  localparam int unsigned SEL_W = idxWidth(DW);

  lsuState_e state, nextState;

  logic              wrReg;
  logic [ADDR_W-1:0] addrReg, strideReg;
  logic [DW-1:0]     wdataReg;
  logic [REG_AW-1:0] wa3Reg;
  logic [LANES-1:0]  remMask;
  logic [IDX_W-1:0]  curLane, pendLane;
  logic              curLast, pendValid;

  logic [LANES-1:0]  scanMask;
  logic [IDX_W-1:0]  scanLane;
  logic              scanAny, scanLast;
  logic [SEL_W-1:0]  scanBase, pendBase;
  logic              accept, issueBeat;

  assign req_ready  = (state == IDLE);
  assign busy       = !req_ready;
  assign accept     = req_valid && req_ready;
  assign issueBeat  = (state == ISSUE) && !flush;
  assign mem_en     = issueBeat;
  assign mem_we     = issueBeat && wrReg;
  assign resp_valid = (state == DONE) && !flush;
  assign resp_write = wrReg;
  assign resp_wa3   = wa3Reg;

  // One scanner serves both the first lane at accept and each following lane.
  assign scanMask = (state == IDLE) ? req_mask : remMask;
  assign scanBase = SEL_W'(scanLane) * SEL_W'(LANE_W);
  assign pendBase = SEL_W'(pendLane) * SEL_W'(LANE_W);

  simd_lane_scan #(.LANES(LANES), .IDX_W(IDX_W)) u_scan (
    .laneMask (scanMask),
    .nextLane (scanLane),
    .anyLane  (scanAny),
    .lastLane (scanLast)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = scanAny ? ISSUE : DONE;
      ISSUE:   if (curLast) nextState = wrReg ? DONE : DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush && !accept) nextState = IDLE;
  end

  // Beat address/data are precomputed one cycle ahead so mem_* leave a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrReg      <= 1'b0;
      addrReg    <= '0;
      strideReg  <= '0;
      wdataReg   <= '0;
      wa3Reg     <= '0;
      remMask    <= '0;
      curLane    <= '0;
      curLast    <= 1'b0;
      pendValid  <= 1'b0;
      pendLane   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        wrReg     <= req_write;
        addrReg   <= req_addr;
        strideReg <= req_stride;
        wdataReg  <= req_wdata;
        wa3Reg    <= req_wa3;
        remMask   <= req_mask & ~(LANES'(1) << scanLane);
        curLane   <= scanLane;
        curLast   <= scanLast;
        mem_addr  <= req_addr + ADDR_W'(scanLane) * req_stride;
        mem_wdata <= req_wdata[scanBase +: LANE_W];
        if (!req_write) resp_rdata <= '0;
      end else if (issueBeat && !curLast) begin
        remMask   <= remMask & ~(LANES'(1) << scanLane);
        curLane   <= scanLane;
        curLast   <= scanLast;
        mem_addr  <= addrReg + ADDR_W'(scanLane) * strideReg;
        mem_wdata <= wdataReg[scanBase +: LANE_W];
      end
      // Read data returns the cycle after its beat; a flush drops it.
      pendValid <= issueBeat && !wrReg;
      pendLane  <= curLane;
      if (pendValid && !flush) resp_rdata[pendBase +: LANE_W] <= mem_rdata;
    end
  end

endmodule
